// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O bridge: data width and interrupt FSM states.
package io_pkg;

  localparam int IO_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE,
    HOLDOFF
  } intr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; the caller only issues legal push/pop, so no guarding is done here.
// The head reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cpu_io_bridge.sv
// Peripheral end of the CPU I/O port: RX buffering with interrupt generation,
// and TX capture of OUT bytes drained to a valid/ready consumer.
module cpu_io_bridge
  import io_pkg::*;
#(
  parameter int RX_DEPTH     = 4,
  parameter int TX_DEPTH     = 4,
  parameter int INTR_PULSE   = 1,
  parameter int INTR_HOLDOFF = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ext_rx_valid,
  input  logic [IO_W-1:0] ext_rx_data,
  output logic            ext_rx_ready,
  output logic [IO_W-1:0] cpu_in_data,
  input  logic            cpu_in_rd,
  output logic            cpu_interrupt,
  input  logic            intr_en,
  input  logic            cpu_out_wr,
  input  logic [IO_W-1:0] cpu_out_data,
  output logic            ext_tx_valid,
  output logic [IO_W-1:0] ext_tx_data,
  input  logic            ext_tx_ready,
  output logic            rx_overflow,
  output logic            rx_underflow,
  output logic            tx_overflow
);

  localparam logic [7:0] PULSE_INIT  = 8'(INTR_PULSE - 1);
  localparam logic [7:0] HOLD_INIT   = 8'(INTR_HOLDOFF - 1);
  localparam bit         HAS_HOLDOFF = (INTR_HOLDOFF != 0);

  logic                      rx_full;
  logic                      rx_empty;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic                      rx_push;
  logic                      rx_pop;

  logic                      tx_full;
  logic                      tx_empty;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic                      tx_push;
  logic                      tx_pop;

  intr_state_t state;
  logic [7:0]  cnt;
  logic        serviced;

  // RX refuses pushes when full even if a pop happens in the same cycle.
  assign ext_rx_ready = !rx_full && !reset;
  assign rx_push      = ext_rx_valid && !rx_full;
  assign rx_pop       = cpu_in_rd && !rx_empty;

  // TX may take a write while full only when the consumer frees a slot that cycle.
  assign ext_tx_valid = !tx_empty;
  assign tx_pop       = ext_tx_ready && (tx_count != '0);
  assign tx_push      = cpu_out_wr && (!tx_full || tx_pop);

  sync_fifo #(.WIDTH(IO_W), .DEPTH(RX_DEPTH)) rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .pop       (rx_pop),
    .push_data (ext_rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count),
    .head      (cpu_in_data)
  );

  sync_fifo #(.WIDTH(IO_W), .DEPTH(TX_DEPTH)) tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .pop       (tx_pop),
    .push_data (cpu_out_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .head      (ext_tx_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      if (ext_rx_valid && rx_full)             rx_overflow  <= 1'b1;
      if (cpu_in_rd && rx_empty)               rx_underflow <= 1'b1;
      if (cpu_out_wr && tx_full && !tx_pop)    tx_overflow  <= 1'b1;
    end
  end

  // A pop seen while the pulse is still high is remembered so the FSM skips SERVICE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      cpu_interrupt <= 1'b0;
      serviced      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (intr_en && rx_count != '0) begin
            state         <= ASSERT;
            cnt           <= PULSE_INIT;
            cpu_interrupt <= 1'b1;
            serviced      <= 1'b0;
          end
        end
        ASSERT: begin
          if (rx_pop) serviced <= 1'b1;
          if (cnt == 8'd0) begin
            cpu_interrupt <= 1'b0;
            if (serviced || rx_pop) begin
              state <= HAS_HOLDOFF ? HOLDOFF : IDLE;
              cnt   <= HOLD_INIT;
            end else begin
              state <= SERVICE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SERVICE: begin
          if (rx_pop) begin
            state <= HAS_HOLDOFF ? HOLDOFF : IDLE;
            cnt   <= HOLD_INIT;
          end
        end
        HOLDOFF: begin
          if (cnt == 8'd0) state <= IDLE;
          else             cnt   <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed self-checking bench for cpu_io_bridge with hand-computed expectations.
module tb_cpu_io_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       ext_rx_valid;
  logic [7:0] ext_rx_data;
  logic       ext_rx_ready;
  logic [7:0] cpu_in_data;
  logic       cpu_in_rd;
  logic       cpu_interrupt;
  logic       intr_en;
  logic       cpu_out_wr;
  logic [7:0] cpu_out_data;
  logic       ext_tx_valid;
  logic [7:0] ext_tx_data;
  logic       ext_tx_ready;
  logic       rx_overflow;
  logic       rx_underflow;
  logic       tx_overflow;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cpu_io_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .ext_rx_valid  (ext_rx_valid),
    .ext_rx_data   (ext_rx_data),
    .ext_rx_ready  (ext_rx_ready),
    .cpu_in_data   (cpu_in_data),
    .cpu_in_rd     (cpu_in_rd),
    .cpu_interrupt (cpu_interrupt),
    .intr_en       (intr_en),
    .cpu_out_wr    (cpu_out_wr),
    .cpu_out_data  (cpu_out_data),
    .ext_tx_valid  (ext_tx_valid),
    .ext_tx_data   (ext_tx_data),
    .ext_tx_ready  (ext_tx_ready),
    .rx_overflow   (rx_overflow),
    .rx_underflow  (rx_underflow),
    .tx_overflow   (tx_overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then samples 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rx_v, input logic [7:0] rx_d, input logic rd,
                               input logic wr, input logic [7:0] wr_d, input logic tx_rdy);
    ext_rx_valid = rx_v;
    ext_rx_data  = rx_d;
    cpu_in_rd    = rd;
    cpu_out_wr   = wr;
    cpu_out_data = wr_d;
    ext_tx_ready = tx_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    intr_en = 1'b0;
    doReset();

    // Reset state
    checkOutput("rst_intr", cpu_interrupt, 0);
    checkOutput("rst_rx_ready", ext_rx_ready, 1);
    checkOutput("rst_tx_valid", ext_tx_valid, 0);
    checkOutput("rst_in_data", cpu_in_data, 0);
    checkOutput("rst_tx_data", ext_tx_data, 0);
    checkOutput("rst_flags", {rx_overflow, rx_underflow, tx_overflow}, 0);

    // RX with interrupt, pulse and holdoff
    intr_en = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rx_head_5a", cpu_in_data, 8'h5A);
    checkOutput("intr_not_yet", cpu_interrupt, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("intr_pulse", cpu_interrupt, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("intr_pulse_end", cpu_interrupt, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("rx_popped", cpu_in_data, 0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("holdoff_1", cpu_interrupt, 0);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("holdoff_%0d", i), cpu_interrupt, 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("intr_after_holdoff", cpu_interrupt, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("intr_second_end", cpu_interrupt, 0);
    checkOutput("rx_head_77", cpu_in_data, 8'h77);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("intr_quiet_%0d", i), cpu_interrupt, 0);
    end
    intr_en = 1'b0;

    // RX full and overflow
    doReset();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
      if (i == 4) checkOutput("rx_full_ready", ext_rx_ready, 0);
    end
    checkOutput("rx_overflow", rx_overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("rx_pop_%0d", i), cpu_in_data, 32'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    end
    checkOutput("rx_drained", cpu_in_data, 0);
    checkOutput("rx_ready_again", ext_rx_ready, 1);
    checkOutput("rx_no_underflow", rx_underflow, 0);

    // Underflow, including read alongside a push into an empty FIFO
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("underflow", rx_underflow, 1);
    checkOutput("underflow_data", cpu_in_data, 0);
    applyStimulus(1'b1, 8'hAB, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("after_underflow_push", cpu_in_data, 8'hAB);
    doReset();
    applyStimulus(1'b1, 8'hCD, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("push_rd_empty_uf", rx_underflow, 1);
    checkOutput("push_rd_empty_data", cpu_in_data, 8'hCD);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("push_rd_empty_pop", cpu_in_data, 0);

    // TX overflow and drain
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
      if (i == 0) checkOutput("tx_valid_latency", ext_tx_valid, 1);
    end
    checkOutput("tx_overflow", tx_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("tx_drain_%0d", i), ext_tx_data, 32'(8'hA0 + 8'(i)));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("tx_empty_valid", ext_tx_valid, 0);
    checkOutput("tx_empty_data", ext_tx_data, 0);

    // TX full with write and pop in the same cycle
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hB0 + 8'(i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hB4, 1'b1);
    checkOutput("tx_full_wr_pop_ovf", tx_overflow, 0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("tx_full_drain_%0d", i), ext_tx_data, 32'(8'hB0 + 8'(i)));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("tx_full_drained", ext_tx_valid, 0);

    // Pointer wrap with simultaneous push/pop at count 1
    doReset();
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      checkOutput($sformatf("wrap_%0d", i), cpu_in_data, 32'(8'h30 + 8'(i - 1)));
      applyStimulus(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
    end
    checkOutput("wrap_last", cpu_in_data, 8'h3A);
    checkOutput("wrap_flags", {rx_overflow, rx_underflow}, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("wrap_count_kept", cpu_in_data, 0);

    // Reset while the interrupt is asserted
    doReset();
    intr_en = 1'b1;
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b1, 8'hEE, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("pre_reset_intr", cpu_interrupt, 1);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("midrst_intr", cpu_interrupt, 0);
    checkOutput("midrst_in_data", cpu_in_data, 0);
    checkOutput("midrst_tx_valid", ext_tx_valid, 0);
    checkOutput("midrst_rx_ready", ext_rx_ready, 0);
    reset = 1'b0;
    #1;
    checkOutput("postrst_rx_ready", ext_rx_ready, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("postrst_intr", cpu_interrupt, 0);
    intr_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
